// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: default widths, reset PC,
// fetch FSM state encoding and the NOP instruction word.
package core_pkg;

    localparam int          DWIDTH   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs in fetch order. Flush empties it in
// one cycle and takes priority over push and pop. The head is read from
// registered storage, so a pushed entry becomes visible the cycle after push.
// Head fields read as zero while the queue is empty.
module fetch_queue
    import core_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int QDEPTH = 4,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_pc,
    input  logic [DWIDTH-1:0] push_instr,
    input  logic              pop,
    output logic [CW-1:0]     count,
    output logic              head_valid,
    output logic [DWIDTH-1:0] head_pc,
    output logic [DWIDTH-1:0] head_instr
);

    logic [DWIDTH-1:0] mem_pc_q    [QDEPTH];
    logic [DWIDTH-1:0] mem_instr_q [QDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    // Pointer and occupancy update; pointers wrap naturally since QDEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control registers; only pointers and count are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc_q[wr_ptr_q]    <= push_pc;
            mem_instr_q[wr_ptr_q] <= push_instr;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_pc    = head_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign head_instr = head_valid ? mem_instr_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Issues sequential imem reads from fetch_pc, keeps
// (queued + outstanding) within QDEPTH so the prefetch queue never overflows,
// and presents in-order {pc, instr} to IF/ID. A redirect flushes the queue and
// marks every in-flight response for discard (DRAIN state).
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt counters.
module fetch_unit
    import core_pkg::*;
#(
    parameter  int                DWIDTH   = core_pkg::DWIDTH,
    parameter  int                QDEPTH   = 4,
    parameter  logic [DWIDTH-1:0] RESET_PC = DWIDTH'(core_pkg::RESET_PC),
    localparam int                OW       = $clog2(QDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [DWIDTH-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_pc,
    output logic [DWIDTH-1:0] if_instr,
    input  logic              if_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    fetch_state_t      state_q,       state_d;
    logic [DWIDTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic [DWIDTH-1:0] rsp_pc_q,      rsp_pc_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [OW-1:0]     discard_q,     discard_d;

    logic [OW-1:0]     q_count;
    logic              q_head_valid;
    logic [DWIDTH-1:0] q_head_pc;
    logic [DWIDTH-1:0] q_head_instr;

    logic              req_ok;
    logic              accept;
    logic              rsp;
    logic              push;
    logic              pop;
    logic [OW-1:0]     out_after;

    // Slots already reserved by in-flight requests count against queue space.
    assign req_ok    = (state_q == RUN) && ((int'(q_count) + int'(outstanding_q)) < QDEPTH);
    assign accept    = imem_req_valid && imem_req_ready;
    assign rsp       = imem_rsp_valid && !rst;
    assign out_after = outstanding_q + OW'(accept) - OW'(rsp);
    assign push      = rsp && (state_q == RUN) && !redirect_valid;
    assign pop       = if_valid && if_ready && !redirect_valid;

    assign imem_req_valid = !rst && req_ok;
    assign imem_req_addr  = rst ? '0 : fetch_pc_q;
    assign if_valid       = !rst && q_head_valid;
    assign if_pc          = rst ? '0 : q_head_pc;
    assign if_instr       = rst ? '0 : q_head_instr;

    fetch_queue #(
        .DWIDTH (DWIDTH),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (rsp_pc_q),
        .push_instr (imem_rsp_data),
        .pop        (pop),
        .count      (q_count),
        .head_valid (q_head_valid),
        .head_pc    (q_head_pc),
        .head_instr (q_head_instr)
    );

    // Next-state logic: redirect overrides everything; rsp_pc tracks the PC of
    // the oldest response that will actually be kept.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = out_after;
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = out_after;
            state_d    = (out_after != '0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) fetch_pc_d = fetch_pc_q + DWIDTH'(4);
                    if (push)   rsp_pc_d   = rsp_pc_q + DWIDTH'(4);
                end
                DRAIN: begin
                    if (rsp) begin
                        discard_d = discard_q - OW'(1);
                        if (discard_q == OW'(1)) state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q,  perf_drop_d;

    // Event counts: accepted requests and responses that were not queued.
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(accept);
        perf_drop_d  = perf_drop_q + 32'(rsp && !push);
    end

    // Performance counter registers, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif

`ifndef SYNTHESIS
    // Responses may only return for requests that were actually accepted.
    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (outstanding_q != '0)
                else $error("fetch_unit: imem response with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. Bench-side imem returns in-order responses with
// random delay; the reference model is the expected PC stream (sequential from
// the last redirect/reset target) held in a scoreboard queue and checked by an
// independent monitor on every IF/ID handshake.
module tb_fetch_unit;

    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // imem model state
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    bit          pend_stale[$];
    int          cyc = 0;
    int          max_pend = 0;

    // reference stream
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          deliv = 0;

    // expected event counts
    int unsigned fetch_exp = 0;
    int unsigned drop_exp  = 0;

    // stimulus knobs
    int p_ready   = 100;
    int p_rsp     = 100;
    int p_ifr     = 100;
    int max_delay = 0;
    bit rsp_en    = 1'b1;
    bit last_acc, last_rsp;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit          acc;
        logic [31:0] a;
        if (redir) begin
            exp_q.delete();
            model_pc = rpc;
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(model_pc);
            model_pc += 32'd4;
        end
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : 32'h0;
        imem_req_ready = ($urandom_range(99) < p_ready);
        if (rsp_en && pend_addr.size() != 0 && cyc >= pend_due[0] && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if_ready = ($urandom_range(99) < p_ifr);
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        a        = imem_req_addr;
        last_acc = acc;
        last_rsp = imem_rsp_valid;
        if (redir) foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (imem_rsp_valid) begin
            if (pend_stale[0]) drop_exp++;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            void'(pend_stale.pop_front());
        end
        if (acc) begin
            fetch_exp++;
            pend_addr.push_back(a);
            pend_due.push_back(cyc + int'($urandom_range(max_delay)));
            pend_stale.push_back(redir);
        end
        if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic quiesce();
        p_ready = 0; rsp_en = 1'b1; p_rsp = 100; p_ifr = 100;
        run(20);
    endtask

    task automatic perf_check(input string tag);
`ifdef FETCH_PERF_EN
        check({tag, "_perf_fetch"}, perf_fetch_cnt, fetch_exp);
        check({tag, "_perf_drop"},  perf_drop_cnt,  drop_exp);
`else
        check({tag, "_stale_left"}, 32'(pend_addr.size()), 32'd0);
`endif
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if_ready = 1'b0;
        @(negedge clk);
        check("rst_if_valid",  32'(if_valid),       32'd0);
        check("rst_if_pc",     if_pc,               32'd0);
        check("rst_if_instr",  if_instr,            32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr",  imem_req_addr,       32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        pend_addr.delete(); pend_due.delete(); pend_stale.delete();
        exp_q.delete();
        model_pc  = 32'h0;
        fetch_exp = 0;
        drop_exp  = 0;
        @(negedge clk);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr",  imem_req_addr,       32'd0);
        check("post_rst_if_valid",  32'(if_valid),       32'd0);
`ifdef FETCH_PERF_EN
        check("post_rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("post_rst_perf_drop",  perf_drop_cnt,  32'd0);
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: compares every IF/ID handshake against the reference stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_valid && if_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", if_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", if_pc, e);
                        check("if_instr", if_instr, instr_of(e));
                    end
                    deliv++;
                end else if (!if_valid) begin
                    check("empty_if_pc", if_pc ^ if_instr, 32'd0);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    initial begin
        int d0;
        do_reset(2);

        // zero-wait imem, IF/ID always ready: one entry per cycle
        p_ready = 100; p_rsp = 100; max_delay = 0; p_ifr = 100; rsp_en = 1'b1;
        d0 = deliv;
        run(30);
        check("zero_wait_rate", 32'(deliv - d0 >= 27), 32'd1);

        // IF/ID stalled: queue fills to QDEPTH and requests stop
        p_ifr = 0;
        run(10);
        check("stall_if_valid",  32'(if_valid),          32'd1);
        check("stall_req_valid", 32'(imem_req_valid),    32'd0);
        check("stall_pending",   32'(pend_addr.size()),  32'd0);
        p_ready = 0; p_ifr = 100;
        d0 = deliv;
        run(8);
        check("stall_buffered", 32'(deliv - d0), 32'(QDEPTH));

        // three outstanding, redirect to 0x100
        rsp_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p_ready = (pend_addr.size() < 3) ? 100 : 0;
            step(1'b0, 32'h0);
        end
        check("three_outstanding", 32'(pend_addr.size()), 32'd3);
        p_ready = 0;
        step(1'b1, 32'h100);
        rsp_en = 1'b1; p_ready = 100;
        d0 = deliv;
        run(20);
        check("post_0x100_flow", 32'(deliv - d0 >= 10), 32'd1);

        // redirect in the same cycle as a response and an accept
        step(1'b1, 32'h400);
        check("redir_acc_rsp", {30'd0, last_acc, last_rsp}, 32'd3);
        run(20);
        quiesce();
        perf_check("directed");

        // redirect, then redirect again while draining
        p_ready = 100; rsp_en = 1'b0;
        run(3);
        step(1'b1, 32'h200);
        step(1'b1, 32'h300);
        rsp_en = 1'b1; p_rsp = 100;
        run(30);
        quiesce();
        perf_check("drain2");

        // randomized traffic with random redirects, including near address wrap
        p_ready = 70; p_rsp = 70; max_delay = 3; p_ifr = 70; rsp_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4)
                step(1'b1, ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC));
            else
                step(1'b0, 32'h0);
        end
        quiesce();
        perf_check("random");

        // reset while draining
        p_ready = 100; p_rsp = 100; max_delay = 0; p_ifr = 100; rsp_en = 1'b0;
        run(3);
        step(1'b1, 32'h500);
        do_reset(1);
        rsp_en = 1'b1;
        d0 = deliv;
        run(30);
        check("post_reset_flow", 32'(deliv - d0 >= 27), 32'd1);
        quiesce();
        perf_check("after_reset");
        check("max_outstanding", 32'(max_pend <= QDEPTH), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
